pipelined_data_mem: RTL
=======================

# pipelined_data_mem

Pipelined, word-organised data-memory responder that serves load/store requests from the CPU's MEM stage and from cache line fills. It accepts at most one request per cycle. Writes commit in the accepting cycle. Read data returns in request order a fixed number of cycles later, tagged by a valid strobe. It sits on the memory side of the MEM-stage interface, opposite the pipeline's request logic.

## Interface
- LATENCY, 4: cycles from read acceptance to `data_valid`; legal range 1..8
- ADDR_W, 16: byte-address width presented by the CPU
- DEPTH_LOG2, 15: log2 of the word count; the array holds 2^DEPTH_LOG2 16-bit words
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  request present this cycle
- wr  input  1  1 = write, 0 = read; ignored when `enable`=0
- addr  input  ADDR_W  byte address; word index is `addr[DEPTH_LOG2:1]`, `addr[0]` ignored
- data_in  input  16  write data
- data_out  output  16  read data; valid only when `data_valid`=1
- data_valid  output  1  one-cycle strobe, one per accepted read
- outstanding  output  4  count of accepted reads not yet returned

## Operation
- Array: 2^DEPTH_LOG2 x 16 bits. `rst` does not clear it; contents persist across reset.
- Address bits above `DEPTH_LOG2` are ignored, so addresses alias modulo the array size.
- Write accept (`enable`=1, `wr`=1): the array word updates at that clock edge.
  - No `data_valid` is produced.
  - `outstanding` does not change.
- Read accept (`enable`=1, `wr`=0): the array word is sampled at the accepting edge and pushed into a LATENCY-deep shift pipeline of {valid, data}.
- Pipeline stage 0 loads {1, sampled word} on a read and {0, 0} otherwise. Every stage advances each cycle. There are no stalls and no back-pressure; the consumer must take data on the strobe cycle.
- `data_out`/`data_valid` come from the last stage registers. When the last stage is invalid, `data_out` = 0.
- `outstanding` update per cycle: +1 on read accept, -1 when the last stage is valid. A simultaneous +1 and -1 leaves it unchanged. It never exceeds LATENCY.
- Ordering rules:
  - A read accepted the cycle after a write to the same word returns the new value.
  - A write to a word while an earlier read of that word is in flight does not affect the in-flight data; the old value is returned.
- Requests are accepted unconditionally. There is no full condition, because the pipeline depth equals LATENCY.
- Reset mid-operation: all in-flight reads are discarded.
  - No `data_valid` fires for them after reset.
  - `outstanding` returns to 0.
  - A write accepted in the cycle before reset is retained.
- A request presented while `rst`=1 is ignored: no write, no read accepted.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `outstanding`=0, all pipeline valid bits 0.
- Read accepted at edge N produces `data_valid`=1 and the data during cycle N+LATENCY, i.e. registered after edge N+LATENCY-1+1.
- With LATENCY=4, a read presented in cycle 0 is strobed in cycle 4.
- Back-to-back reads give back-to-back strobes, in issue order, one per cycle.
- Write commits at the accepting edge. A read presented in the next cycle observes it.
- `outstanding` is registered and reflects requests accepted up to the previous edge.

## Test plan
- Basic write/read, LATENCY=4:
  - Stimulus: write 0xBEEF to addr 0x0010 in cycle 0; read 0x0010 in cycle 1.
  - Required: `data_valid`=1 and `data_out`=0xBEEF in cycle 5 only; `outstanding` reads 1,1,1,1 then 0.
- Burst fill:
  - Stimulus: preload 0x0020..0x002E (word values 1..8); issue 8 consecutive reads.
  - Required: 8 consecutive strobes returning 1..8 in order; `outstanding` peaks at 4.
- In-flight hazard:
  - Stimulus: word 0x0040 = 0x1111; read 0x0040 in cycle 0; write 0x2222 to it in cycle 1; read it again in cycle 2.
  - Required: strobes return 0x1111, then 0x2222.
- Aliasing and byte bit:
  - Stimulus: write 0x00AA to addr 0x0005; read addr 0x0004; with DEPTH_LOG2=8, also read addr 0x0204.
  - Required: both reads return 0x00AA.
- Reset mid-flight:
  - Stimulus: 3 reads issued, `rst` asserted for 1 cycle two cycles later.
  - Required: no `data_valid` afterwards; `outstanding`=0 and `data_out`=0 the cycle after reset; array contents intact on a later read.
- Idle/mixed traffic:
  - Stimulus: random interleave of `enable`/`wr` for 200 cycles against a reference array with a LATENCY-delay queue.
  - Required: every strobe matches the queued value; strobe count equals read count; `outstanding` is never above 4.

Source files
------------

// File: rtl/pipelined_data_mem_if.sv
// Request/response bundle between the MEM-stage request logic (master) and the data memory (slave).
interface pipelined_data_mem_if #(
    parameter int ADDR_W = 16
);
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_in;
    logic [15:0]       data_out;
    logic              data_valid;
    logic [3:0]        outstanding;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, outstanding
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, outstanding
    );
endinterface

// File: rtl/pipelined_data_mem.sv
// Word-organised data memory: writes commit at the accepting edge, reads return in order LATENCY cycles later.
// No back-pressure: one request per cycle is always accepted and the consumer must take data on the strobe.
module pipelined_data_mem #(
    parameter int LATENCY    = 4,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_data_mem_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [LATENCY-1:0]    stg_vld;
    logic [15:0]           stg_dat [LATENCY];
    logic [3:0]            outstanding_q;
    logic                  unused_addr_bits;

    assign idx    = bus.addr[DEPTH_LOG2:1];
    assign rd_acc = bus.enable && !bus.wr && !rst;
    assign wr_acc = bus.enable &&  bus.wr && !rst;

    // Only the byte bit and the aliased high bits go unused; they are folded here deliberately.
    assign unused_addr_bits = ^bus.addr;

    // The array is never reset, so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld       <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_dat[i] <= '0;
            end
        end else begin
            // Stage 0 loads zero when idle so the output word is 0 whenever the strobe is low.
            stg_vld[0] <= rd_acc;
            stg_dat[0] <= rd_acc ? mem[idx] : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_dat[i] <= stg_dat[i-1];
            end
            case ({rd_acc, stg_vld[LATENCY-1]})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign bus.data_out    = stg_dat[LATENCY-1];
    assign bus.data_valid  = stg_vld[LATENCY-1];
    assign bus.outstanding = outstanding_q;
endmodule
